packed_frame_checker: RTL and testbench

//  Receive end of the packed-constant driver path. The driver side emits a fixed
//  4-state packed pattern as a 1-bit serial stream, MSB first. This block:
//   - accepts the stream over a valid/ready handshake and rebuilds one FRAME_W frame;
//   - compares the frame to the expected constant, counting mismatching and X/Z bits;
//   - keeps saturating good/bad frame counters.
//  It sits on the bench side of generated designs, as the checker for constant drivers.

---
 rtl/frame_chk_pkg.sv | 23 ++
 rtl/frame_popcount.sv | 18 +
 rtl/packed_frame_checker.sv | 157 +++++++++++++++
 tb/tb_packed_frame_checker.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_chk_pkg.sv
// rtl/frame_chk_pkg.sv - Shared types, frame defaults and counter helper for the packed frame checker
package frame_chk_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        REPORT  = 2'd3
    } state_e;

    localparam int FRAME_W_DEF = 48;

    // [2:1][4:1][1:3][0:1] flattened; the driver's 8A5_3C0F_6E19_B247 literal sized to 48 bits
    localparam logic [FRAME_W_DEF-1:0] EXP_FRAME_DEF = 48'h3C0F_6E19_B247;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] cnt_sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/frame_popcount.sv
// rtl/frame_popcount.sv - Combinational population count of a W-bit vector
module frame_popcount #(
    parameter int W = 48
) (
    input  logic [W-1:0]             vec,
    output logic [$clog2(W+1)-1:0]   count
);

    localparam int CW = $clog2(W + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(vec[i]);
        end
    end

endmodule

// File: rtl/packed_frame_checker.sv
// rtl/packed_frame_checker.sv - Rebuilds a serial MSB-first frame and checks it against a 4-state constant
module packed_frame_checker
    import frame_chk_pkg::*;
#(
    parameter int                 FRAME_W   = FRAME_W_DEF,
    parameter logic [FRAME_W-1:0] EXP_FRAME = EXP_FRAME_DEF,
    parameter int                 CNT_W     = 8,
    parameter int                 TIMEOUT   = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         in_sof,
    input  logic                         in_data,
    output logic                         in_ready,
    output logic                         frame_done,
    output logic                         match,
    output logic                         xz_seen,
    output logic [$clog2(FRAME_W+1)-1:0] mismatch_bits,
    output logic                         abort,
    output logic [CNT_W-1:0]             frames_ok,
    output logic [CNT_W-1:0]             frames_bad
);

    localparam int BC_W = $clog2(FRAME_W + 1);
    localparam int IC_W = $clog2(TIMEOUT);

    state_e              state_q;
    state_e              state_d;
    logic [FRAME_W-1:0]  frame_q;
    logic [BC_W-1:0]     bit_cnt_q;
    logic [IC_W-1:0]     idle_cnt_q;
    logic [FRAME_W-1:0]  unknown;
    logic [FRAME_W-1:0]  mism;
    logic [BC_W-1:0]     mism_cnt;
    logic                beat;
    logic                timed_out;

    assign beat      = in_valid & in_ready;
    assign timed_out = (state_q == COLLECT) && !in_valid && (idle_cnt_q == IC_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        frame_done = 1'b0;
        abort      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && in_sof) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (!in_sof && (bit_cnt_q == BC_W'(FRAME_W - 1))) begin
                        state_d = CHECK;
                    end
                end else if (timed_out) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            CHECK: begin
                state_d = REPORT;
            end
            REPORT: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Case equality keeps x/z visible as "unknown" rather than letting them propagate.
    always_comb begin
        unknown = '0;
        mism    = '0;
        for (int i = 0; i < FRAME_W; i++) begin
            unknown[i] = !((frame_q[i] === 1'b0) || (frame_q[i] === 1'b1));
            mism[i]    = unknown[i] | (frame_q[i] ^ EXP_FRAME[i]);
        end
    end

    frame_popcount #(
        .W (FRAME_W)
    ) u_popcount (
        .vec   (mism),
        .count (mism_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q       <= '0;
            bit_cnt_q     <= '0;
            idle_cnt_q    <= '0;
            match         <= 1'b0;
            xz_seen       <= 1'b0;
            mismatch_bits <= '0;
            frames_ok     <= '0;
            frames_bad    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (beat && in_sof) begin
                        frame_q    <= {{(FRAME_W - 1){1'b0}}, in_data};
                        bit_cnt_q  <= BC_W'(1);
                        idle_cnt_q <= '0;
                    end
                end
                COLLECT: begin
                    if (beat) begin
                        idle_cnt_q <= '0;
                        if (in_sof) begin
                            frame_q   <= {{(FRAME_W - 1){1'b0}}, in_data};
                            bit_cnt_q <= BC_W'(1);
                        end else begin
                            frame_q   <= {frame_q[FRAME_W-2:0], in_data};
                            bit_cnt_q <= bit_cnt_q + BC_W'(1);
                        end
                    end else begin
                        idle_cnt_q <= idle_cnt_q + IC_W'(1);
                        if (timed_out) begin
                            frames_bad <= CNT_W'(cnt_sat_inc(32'(frames_bad), CNT_W));
                        end
                    end
                end
                CHECK: begin
                    mismatch_bits <= mism_cnt;
                    xz_seen       <= |unknown;
                    match         <= (mism_cnt == '0);
                end
                REPORT: begin
                    if (match) begin
                        frames_ok <= CNT_W'(cnt_sat_inc(32'(frames_ok), CNT_W));
                    end else begin
                        frames_bad <= CNT_W'(cnt_sat_inc(32'(frames_bad), CNT_W));
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packed_frame_checker.sv
// tb/tb_packed_frame_checker.sv - Self-checking bench for packed_frame_checker
module tb_packed_frame_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_sof = 1'b0;
    logic in_data = 1'b0;

    logic       in_ready, frame_done, match, xz_seen, abort;
    logic [5:0] mismatch_bits;
    logic [7:0] frames_ok, frames_bad;

    logic       in_ready2, frame_done2, match2, xz_seen2, abort2;
    logic [5:0] mismatch_bits2;
    logic [1:0] frames_ok2, frames_bad2;

    logic [47:0] exp_frame = 48'h3C0F_6E19_B247;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_abort = 0;
    int m_ok = 0;
    int m_bad = 0;

    packed_frame_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .in_ready(in_ready), .frame_done(frame_done), .match(match), .xz_seen(xz_seen),
        .mismatch_bits(mismatch_bits), .abort(abort),
        .frames_ok(frames_ok), .frames_bad(frames_bad)
    );

    packed_frame_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .in_ready(in_ready2), .frame_done(frame_done2), .match(match2), .xz_seen(xz_seen2),
        .mismatch_bits(mismatch_bits2), .abort(abort2),
        .frames_ok(frames_ok2), .frames_bad(frames_bad2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) n_done++;
        if (abort) n_abort++;
    end

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_counters();
        chk("frames_ok", 64'(frames_ok), 64'(sat(m_ok, 8)));
        chk("frames_bad", 64'(frames_bad), 64'(sat(m_bad, 8)));
        chk("frames_ok_w2", 64'(frames_ok2), 64'(sat(m_ok, 2)));
        chk("frames_bad_w2", 64'(frames_bad2), 64'(sat(m_bad, 2)));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_ok = 0;
        m_bad = 0;
    endtask

    task automatic beat(input logic sof, input logic d);
        in_valid = 1'b1;
        in_sof = sof;
        in_data = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_data = 1'b0;
    endtask

    // Idle cycles with garbage on the qualifier-gated lines.
    task automatic gap(input int k);
        repeat (k) begin
            in_sof = 1'($urandom);
            in_data = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_sof = 1'b0;
        in_data = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) chk("ready_in_check", 64'(in_ready), 64'd0);
            if (frame_done) begin
                lat = c;
                break;
            end
        end
    endtask

    // pre: junk beats (first carries sof) before the real frame; long_gap: stall before bit 23.
    task automatic run_frame(input logic [47:0] f, input bit stall, input int pre, input int long_gap);
        int lat;
        int exp_n;
        int done0;
        int ab0;
        exp_n = 0;
        for (int i = 0; i < 48; i++) begin
            if (f[i] !== exp_frame[i]) exp_n++;
        end
        done0 = n_done;
        ab0 = n_abort;
        for (int i = 0; i < pre; i++) begin
            beat(i == 0, 1'($urandom));
        end
        for (int i = 47; i >= 0; i--) begin
            if (stall) gap($urandom_range(0, 3));
            if (i == 23) gap(long_gap);
            beat(i == 47, f[i]);
        end
        wait_done(lat);
        chk("latency", 64'(lat), 64'd2);
        chk("match", 64'(match), 64'(exp_n == 0));
        chk("mismatch_bits", 64'(mismatch_bits), 64'(exp_n));
        chk("xz_seen", 64'(xz_seen), 64'($isunknown(f)));
        if (exp_n == 0) m_ok++;
        else m_bad++;
        @(negedge clk);
        chk_counters();
        chk("ready_idle", 64'(in_ready), 64'd1);
        #1;
        chk("done_pulses", 64'(n_done - done0), 64'd1);
        chk("no_abort", 64'(n_abort - ab0), 64'd0);
    endtask

    initial begin
        logic [47:0] f;
        int first;
        int cnt_ab;
        int done0;
        int idx;

        do_reset();
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_match", 64'(match), 64'd0);
        chk("rst_xz_seen", 64'(xz_seen), 64'd0);
        chk("rst_mismatch", 64'(mismatch_bits), 64'd0);
        chk("rst_abort", 64'(abort), 64'd0);
        chk_counters();

        run_frame(exp_frame, 1'b0, 0, 0);

        f = exp_frame;
        f[47] = ~f[47];
        f[0] = ~f[0];
        run_frame(f, 1'b0, 0, 0);

        f = exp_frame;
        f[5] = 1'bz;
        f[20] = 1'bx;
        run_frame(f, 1'b0, 0, 0);

        done0 = n_done;
        for (int i = 0; i < 10; i++) beat(i == 0, exp_frame[47-i]);
        first = 0;
        cnt_ab = 0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (abort) begin
                cnt_ab++;
                if (first == 0) first = c;
            end
        end
        chk("abort_cycle", 64'(first), 64'd64);
        chk("abort_pulses", 64'(cnt_ab), 64'd1);
        m_bad++;
        chk_counters();
        chk("ready_after_abort", 64'(in_ready), 64'd1);
        #1;
        chk("no_done_on_abort", 64'(n_done - done0), 64'd0);

        run_frame(exp_frame, 1'b0, 29, 0);
        run_frame(exp_frame, 1'b0, 0, 63);

        for (int r = 0; r < 10; r++) begin
            f = exp_frame;
            repeat ($urandom_range(0, 3)) begin
                idx = $urandom_range(0, 47);
                f[idx] = ~f[idx];
            end
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, 47);
                f[idx] = 1'bx;
            end
            run_frame(f, 1'b1, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : 0, 0);
        end

        do_reset();
        for (int r = 0; r < 5; r++) run_frame(exp_frame, r[0], 0, 0);

        for (int i = 0; i < 20; i++) beat(i == 0, exp_frame[47-i]);
        do_reset();
        @(negedge clk);
        chk("rst2_in_ready", 64'(in_ready), 64'd1);
        chk("rst2_match", 64'(match), 64'd0);
        chk("rst2_mismatch", 64'(mismatch_bits), 64'd0);
        chk_counters();
        run_frame(exp_frame, 1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
